// File: rtl/line_mem_responder.sv
// Line-granular backing memory answering the 128-bit cache-line protocol with a
// fixed response latency and a mandatory recovery cycle after every response.
module line_mem_responder #(
    parameter int unsigned LATENCY    = 4,
    parameter int unsigned INDEX_BITS = 12
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [15:0]  mem_address,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [127:0] mem_wdata,
    output logic [127:0] mem_rdata,
    output logic         mem_resp,
    output logic         busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP,
        S_RECOVER
    } state_e;

    localparam int unsigned LINES  = 2 ** INDEX_BITS;
    localparam logic [3:0]  LAT_M2 = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [INDEX_BITS-1:0]   idx_q, idx_d;
    logic                    rd_q, rd_d;
    logic [127:0]            rdata_q, rdata_d;
    logic                    resp_q, resp_d;
    logic                    busy_q, busy_d;
    logic [127:0]            line_q [LINES];

    logic [INDEX_BITS-1:0]   req_idx;
    logic                    do_write;
    logic                    unused_addr_bits;

    // Upper address bits alias; low nibble is the byte offset within the line.
    assign req_idx          = mem_address[INDEX_BITS+3:4];
    assign unused_addr_bits = ^mem_address;
    assign do_write         = (state_q == S_IDLE) && mem_write;

    // NOTE: the line array has no reset so it maps onto RAM and survives reset.
    always_ff @(posedge clk) begin
        if (do_write) begin
            line_q[req_idx] <= mem_wdata;
        end
    end

    // NOTE: every comb output is defaulted first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rd_d    = rd_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (mem_read || mem_write) begin
                    idx_d = req_idx;
                    rd_d  = mem_read && !mem_write;
                    if (LATENCY == 1) begin
                        state_d = S_RESP;
                    end else begin
                        cnt_d   = LAT_M2;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP:    state_d = S_RECOVER;
            S_RECOVER: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
        // Read data lands on the edge entering RESP; writes leave it untouched.
        if (state_d == S_RESP && rd_d) begin
            rdata_d = line_q[idx_d];
        end
        resp_d = (state_d == S_RESP);
        busy_d = (state_d != S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            rd_q    <= 1'b0;
            rdata_q <= '0;
            resp_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rd_q    <= rd_d;
            rdata_q <= rdata_d;
            resp_q  <= resp_d;
            busy_q  <= busy_d;
        end
    end

    assign mem_rdata = rdata_q;
    assign mem_resp  = resp_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_line_mem_responder.sv
// Directed bench for line_mem_responder: two instances (latency 4 / 12 index bits,
// latency 1 / 4 index bits) checked against a line model and a response scoreboard.
module tb_line_mem_responder;

    typedef struct {
        int           cyc;
        logic [127:0] rdata;
        string        tag;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    logic         clk   = 1'b0;
    logic         reset = 1'b1;
    logic [15:0]  addr  [2];
    logic         rd    [2];
    logic         wr    [2];
    logic [127:0] wdata [2];
    logic [127:0] rdata [2];
    logic         resp  [2];
    logic         busy  [2];

    int           lat [2] = '{4, 1};
    int           ib  [2] = '{12, 4};
    logic [127:0] model_mem [int];
    logic [127:0] model_rdata [2];

    localparam logic [127:0] D1   = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] D2   = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    localparam logic [127:0] D3   = 128'h55555555_AAAAAAAA_55555555_AAAAAAAA;
    localparam logic [127:0] D4   = 128'h0F0F0F0F_F0F0F0F0_13579BDF_2468ACE0;
    localparam logic [127:0] D5   = 128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C;
    localparam logic [127:0] D6   = 128'h11111111_22222222_33333333_44444444;
    localparam logic [127:0] ONES = {128{1'b1}};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    line_mem_responder #(.LATENCY(4), .INDEX_BITS(12)) u_dut0 (
        .clk        (clk),
        .reset      (reset),
        .mem_address(addr[0]),
        .mem_read   (rd[0]),
        .mem_write  (wr[0]),
        .mem_wdata  (wdata[0]),
        .mem_rdata  (rdata[0]),
        .mem_resp   (resp[0]),
        .busy       (busy[0])
    );

    line_mem_responder #(.LATENCY(1), .INDEX_BITS(4)) u_dut1 (
        .clk        (clk),
        .reset      (reset),
        .mem_address(addr[1]),
        .mem_read   (rd[1]),
        .mem_write  (wr[1]),
        .mem_wdata  (wdata[1]),
        .mem_rdata  (rdata[1]),
        .mem_resp   (resp[1]),
        .busy       (busy[1])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Pops the oldest expected response and compares arrival cycle and read data.
    task automatic check_resp(input int d);
        exp_t e;
        bit   have;
        have = (d == 0) ? (sb0.size() > 0) : (sb1.size() > 0);
        vectors++;
        assert (have) else begin
            miscompares++;
            $error("FAIL dut%0d spurious_resp: observed mem_resp=1 at cycle %0d expected none", d, cyc);
        end
        if (have) begin
            if (d == 0) e = sb0.pop_front();
            else        e = sb1.pop_front();
            vectors++;
            assert (cyc === e.cyc) else begin
                miscompares++;
                $error("FAIL %s latency: observed cycle %0d expected %0d", e.tag, cyc, e.cyc);
            end
            check_val({e.tag, " rdata"}, rdata[d], e.rdata);
        end
    endtask

    always @(negedge clk) if (!reset && resp[0]) check_resp(0);
    always @(negedge clk) if (!reset && resp[1]) check_resp(1);

    // Requester: holds the request until mem_resp, drops it in RECOVER, then
    // confirms the responder stays idle for two cycles.
    task automatic txn(input int d, input string tag, input logic [15:0] a,
                       input logic r, input logic w, input logic [127:0] wd,
                       input bit chg, input logic [15:0] a2, input logic [127:0] wd2);
        exp_t e;
        int   key;
        bit   got;
        key = d * 65536 + ((int'(a) >> 4) & ((1 << ib[d]) - 1));
        if (w) begin
            model_mem[key] = wd;
            e.rdata = model_rdata[d];
        end else begin
            e.rdata = model_mem[key];
            model_rdata[d] = e.rdata;
        end
        e.cyc = cyc + lat[d];
        e.tag = tag;
        if (d == 0) sb0.push_back(e);
        else        sb1.push_back(e);
        addr[d]  = a;
        rd[d]    = r;
        wr[d]    = w;
        wdata[d] = wd;
        if (chg) begin
            repeat (2) tick();
            addr[d]  = a2;
            wdata[d] = wd2;
        end
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = resp[d];
        end
        vectors++;
        assert (got) else begin
            miscompares++;
            $error("FAIL %s timeout: observed no mem_resp expected one within 20 cycles", tag);
        end
        tick();
        rd[d] = 1'b0;
        wr[d] = 1'b0;
        tick();
        @(negedge clk);
        check_val({tag, " busy_idle"}, 128'(busy[d]), 128'd0);
        tick();
        @(negedge clk);
        check_val({tag, " no_second_txn"}, 128'(busy[d]), 128'd0);
        tick();
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            addr[d]        = '0;
            rd[d]          = 1'b0;
            wr[d]          = 1'b0;
            wdata[d]       = '0;
            model_rdata[d] = '0;
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check_val($sformatf("dut%0d reset rdata", d), rdata[d], 128'd0);
            check_val($sformatf("dut%0d reset resp", d), 128'(resp[d]), 128'd0);
            check_val($sformatf("dut%0d reset busy", d), 128'(busy[d]), 128'd0);
        end
        tick();

        txn(0, "wr_1230",      16'h1230, 1'b0, 1'b1, D1,   1'b0, 16'h0, '0);
        txn(0, "rd_123C",      16'h123C, 1'b1, 1'b0, '0,   1'b0, 16'h0, '0);
        txn(0, "dual_0040",    16'h0040, 1'b1, 1'b1, ONES, 1'b0, 16'h0, '0);
        txn(0, "rd_0040",      16'h0040, 1'b1, 1'b0, '0,   1'b0, 16'h0, '0);
        txn(0, "wr_0600",      16'h0600, 1'b0, 1'b1, D4,   1'b0, 16'h0, '0);
        txn(0, "wr_0500_chg",  16'h0500, 1'b0, 1'b1, D2,   1'b1, 16'h0600, D3);
        txn(0, "rd_0600",      16'h0600, 1'b1, 1'b0, '0,   1'b0, 16'h0, '0);
        txn(0, "rd_0500",      16'h0500, 1'b1, 1'b0, '0,   1'b0, 16'h0, '0);
        txn(0, "rd_1230_chg",  16'h1230, 1'b1, 1'b0, '0,   1'b1, 16'h0040, '0);

        // Reset two cycles into a read: no response, outputs cleared at once.
        addr[0] = 16'h0500;
        rd[0]   = 1'b1;
        tick();
        tick();
        #2 reset = 1'b1;
        #1;
        check_val("midreset rdata", rdata[0], 128'd0);
        check_val("midreset busy", 128'(busy[0]), 128'd0);
        check_val("midreset resp", 128'(resp[0]), 128'd0);
        rd[0] = 1'b0;
        tick();
        reset          = 1'b0;
        model_rdata[0] = '0;
        model_rdata[1] = '0;
        tick();
        @(negedge clk);
        check_val("postreset busy", 128'(busy[0]), 128'd0);
        tick();
        txn(0, "rd_1230_postreset", 16'h1230, 1'b1, 1'b0, '0, 1'b0, 16'h0, '0);

        txn(1, "l1_wr_0010",   16'h0010, 1'b0, 1'b1, D5,   1'b0, 16'h0, '0);
        txn(1, "l1_rd_0110",   16'h0110, 1'b1, 1'b0, '0,   1'b0, 16'h0, '0);
        txn(1, "l1_wr_0020",   16'h0020, 1'b0, 1'b1, D6,   1'b0, 16'h0, '0);
        txn(1, "l1_rd_0F20",   16'h 0F20, 1'b1, 1'b0, '0,  1'b0, 16'h0, '0);

        repeat (3) tick();
        vectors++;
        assert (sb0.size() == 0 && sb1.size() == 0) else begin
            miscompares++;
            $error("FAIL scoreboard_drain: observed %0d/%0d pending expected 0/0", sb0.size(), sb1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
